des_round_sequencer: RTL and testbench

DES_ROUND_SEQUENCER -- requirements
Module: des_round_sequencer

---
 rtl/des_round_sequencer.sv | 245 ++++++++++++++++++++++++
 tb/tb_des_round_sequencer.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/des_round_sequencer.sv
// Iterative DES core: one shared round function, sixteen clocks per block.
// Decrypt walks the key schedule backwards by rotating right.
module des_round_sequencer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        decrypt,
  input  logic [63:0] data_in,
  input  logic [63:0] key_in,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] data_out,
  output logic        busy,
  output logic [4:0]  round
);

  typedef enum logic [1:0] {IDLE = 2'd0, ROUND = 2'd1, DONE = 2'd2} state_t;

  localparam logic [6:0] IP_T [64] = '{
    7'd58, 7'd50, 7'd42, 7'd34, 7'd26, 7'd18, 7'd10, 7'd2,
    7'd60, 7'd52, 7'd44, 7'd36, 7'd28, 7'd20, 7'd12, 7'd4,
    7'd62, 7'd54, 7'd46, 7'd38, 7'd30, 7'd22, 7'd14, 7'd6,
    7'd64, 7'd56, 7'd48, 7'd40, 7'd32, 7'd24, 7'd16, 7'd8,
    7'd57, 7'd49, 7'd41, 7'd33, 7'd25, 7'd17, 7'd9,  7'd1,
    7'd59, 7'd51, 7'd43, 7'd35, 7'd27, 7'd19, 7'd11, 7'd3,
    7'd61, 7'd53, 7'd45, 7'd37, 7'd29, 7'd21, 7'd13, 7'd5,
    7'd63, 7'd55, 7'd47, 7'd39, 7'd31, 7'd23, 7'd15, 7'd7};

  localparam logic [6:0] PC1_T [56] = '{
    7'd57, 7'd49, 7'd41, 7'd33, 7'd25, 7'd17, 7'd9,
    7'd1,  7'd58, 7'd50, 7'd42, 7'd34, 7'd26, 7'd18,
    7'd10, 7'd2,  7'd59, 7'd51, 7'd43, 7'd35, 7'd27,
    7'd19, 7'd11, 7'd3,  7'd60, 7'd52, 7'd44, 7'd36,
    7'd63, 7'd55, 7'd47, 7'd39, 7'd31, 7'd23, 7'd15,
    7'd7,  7'd62, 7'd54, 7'd46, 7'd38, 7'd30, 7'd22,
    7'd14, 7'd6,  7'd61, 7'd53, 7'd45, 7'd37, 7'd29,
    7'd21, 7'd13, 7'd5,  7'd28, 7'd20, 7'd12, 7'd4};

  localparam logic [5:0] PC2_T [48] = '{
    6'd14, 6'd17, 6'd11, 6'd24, 6'd1,  6'd5,  6'd3,  6'd28,
    6'd15, 6'd6,  6'd21, 6'd10, 6'd23, 6'd19, 6'd12, 6'd4,
    6'd26, 6'd8,  6'd16, 6'd7,  6'd27, 6'd20, 6'd13, 6'd2,
    6'd41, 6'd52, 6'd31, 6'd37, 6'd47, 6'd55, 6'd30, 6'd40,
    6'd51, 6'd45, 6'd33, 6'd48, 6'd44, 6'd49, 6'd39, 6'd56,
    6'd34, 6'd53, 6'd46, 6'd42, 6'd50, 6'd36, 6'd29, 6'd32};

  localparam logic [5:0] P_T [32] = '{
    6'd16, 6'd7,  6'd20, 6'd21, 6'd29, 6'd12, 6'd28, 6'd17,
    6'd1,  6'd15, 6'd23, 6'd26, 6'd5,  6'd18, 6'd31, 6'd10,
    6'd2,  6'd8,  6'd24, 6'd14, 6'd32, 6'd27, 6'd3,  6'd9,
    6'd19, 6'd13, 6'd30, 6'd6,  6'd22, 6'd11, 6'd4,  6'd25};

  // Each S-box is its four rows of sixteen nibbles, row 0 in the top bits.
  localparam logic [255:0] SBOX_T [8] = '{
    {64'hE4D12FB83A6C5907, 64'h0F74E2D1A6CB9538, 64'h41E8D62BFC973A50, 64'hFC8249175B3EA06D},
    {64'hF18E6B34972DC05A, 64'h3D47F28EC01A69B5, 64'h0E7BA4D158C6932F, 64'hD8A13F42B67C05E9},
    {64'hA09E63F51DC7B428, 64'hD709346A285ECBF1, 64'hD6498F30B12C5AE7, 64'h1AD069874FE3B52C},
    {64'h7DE3069A1285BC4F, 64'hD8B56F03472C1AE9, 64'hA690CB7DF13E5284, 64'h3F06A1D8945BC72E},
    {64'h2C417AB6853FD0E9, 64'hEB2C47D150FA3986, 64'h421BAD78F9C5630E, 64'hB8C71E2D6F09A453},
    {64'hC1AF92680D34E75B, 64'hAF427C9561DE0B38, 64'h9EF528C3704A1DB6, 64'h432C95FABE17608D},
    {64'h4B2EF08D3C975A61, 64'hD0B7491AE35C2F86, 64'h14BDC37EAF680592, 64'h6BD814A7950FE23C},
    {64'hD2846FB1A93E50C7, 64'h1FD8A374C56B0E92, 64'h7B419CE206ADF358, 64'h21E74A8DFC90356B}};

  // Table entries are 1-based DES bit numbers with bit 1 at the MSB.
  function automatic logic [63:0] ip_f(input logic [63:0] x);
    logic [63:0] y;
    logic [6:0]  src;
    y = 64'd0;
    for (int i = 0; i < 64; i++) begin
      src       = 7'd64 - IP_T[i];
      y[63 - i] = x[src[5:0]];
    end
    return y;
  endfunction

  function automatic logic [63:0] ip_inv_f(input logic [63:0] x);
    logic [63:0] y;
    logic [6:0]  dst;
    y = 64'd0;
    for (int i = 0; i < 64; i++) begin
      dst         = 7'd64 - IP_T[i];
      y[dst[5:0]] = x[63 - i];
    end
    return y;
  endfunction

  function automatic logic [55:0] pc1_f(input logic [63:0] x);
    logic [55:0] y;
    logic [6:0]  src;
    y = 56'd0;
    for (int i = 0; i < 56; i++) begin
      src       = 7'd64 - PC1_T[i];
      y[55 - i] = x[src[5:0]];
    end
    return y;
  endfunction

  function automatic logic [47:0] pc2_f(input logic [55:0] x);
    logic [47:0] y;
    logic [5:0]  src;
    y = 48'd0;
    for (int i = 0; i < 48; i++) begin
      src       = 6'd56 - PC2_T[i];
      y[47 - i] = x[src];
    end
    return y;
  endfunction

  function automatic logic [3:0] sbox_f(input logic [2:0] n, input logic [5:0] b);
    logic [255:0] t;
    logic [5:0]   k;
    t = SBOX_T[n];
    k = {b[5], b[0], b[4:1]};
    return t[8'd255 - {k, 2'b00} -: 4];
  endfunction

  function automatic logic [31:0] f_f(input logic [31:0] r, input logic [47:0] k);
    logic [33:0] x;
    logic [47:0] e;
    logic [31:0] s;
    logic [31:0] y;
    logic [5:0]  src;
    x = {r[0], r, r[31]};
    e = 48'd0;
    s = 32'd0;
    y = 32'd0;
    for (int j = 0; j < 8; j++) e[47 - 6*j -: 6] = x[33 - 4*j -: 6];
    e = e ^ k;
    for (int j = 0; j < 8; j++) s[31 - 4*j -: 4] = sbox_f(3'(j), e[47 - 6*j -: 6]);
    for (int i = 0; i < 32; i++) begin
      src       = 6'd32 - P_T[i];
      y[31 - i] = s[src[4:0]];
    end
    return y;
  endfunction

  function automatic logic [27:0] rot_f(input logic [27:0] x, input logic [2:0] op);
    case (op)
      3'd1:    return {x[26:0], x[27]};
      3'd2:    return {x[25:0], x[27:26]};
      3'd3:    return {x[0], x[27:1]};
      3'd4:    return {x[1:0], x[27:2]};
      default: return x;
    endcase
  endfunction

  state_t      state_q, state_d;
  logic [31:0] l_q, l_d, r_q, r_d;
  logic [55:0] cd_q, cd_d;
  logic        mode_q, mode_d;
  logic [4:0]  round_q, round_d;
  logic [63:0] dout_q, dout_d;
  logic        one_s;
  logic [2:0]  rot_op_s;
  logic [55:0] cd_rot_s;
  logic [31:0] f_s;

  // Per-round rotation: encrypt goes left, decrypt goes right and skips round 1.
  always_comb begin
    one_s    = (round_q == 5'd1) || (round_q == 5'd2) || (round_q == 5'd9) || (round_q == 5'd16);
    rot_op_s = 3'd0;
    if (!mode_q) begin
      rot_op_s = one_s ? 3'd1 : 3'd2;
    end else if (round_q == 5'd1) begin
      rot_op_s = 3'd0;
    end else begin
      rot_op_s = one_s ? 3'd3 : 3'd4;
    end
    cd_rot_s = {rot_f(cd_q[55:28], rot_op_s), rot_f(cd_q[27:0], rot_op_s)};
    f_s      = f_f(r_q, pc2_f(cd_rot_s));
  end

  // Next-state logic for the three-state sequencer and its datapath.
  always_comb begin
    state_d = state_q;
    l_d     = l_q;
    r_d     = r_q;
    cd_d    = cd_q;
    mode_d  = mode_q;
    round_d = round_q;
    dout_d  = dout_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          {l_d, r_d} = ip_f(data_in);
          cd_d       = pc1_f(key_in);
          mode_d     = decrypt;
          round_d    = 5'd1;
          state_d    = ROUND;
        end else begin
          state_d = IDLE;
        end
      end
      ROUND: begin
        l_d  = r_q;
        r_d  = l_q ^ f_s;
        cd_d = cd_rot_s;
        if (round_q == 5'd16) begin
          dout_d  = ip_inv_f({r_d, l_d});
          round_d = 5'd0;
          state_d = DONE;
        end else begin
          round_d = round_q + 5'd1;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end else begin
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      l_q     <= 32'd0;
      r_q     <= 32'd0;
      cd_q    <= 56'd0;
      mode_q  <= 1'b0;
      round_q <= 5'd0;
      dout_q  <= 64'd0;
    end else begin
      state_q <= state_d;
      l_q     <= l_d;
      r_q     <= r_d;
      cd_q    <= cd_d;
      mode_q  <= mode_d;
      round_q <= round_d;
      dout_q  <= dout_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign out_valid = (state_q == DONE);
  assign data_out  = dout_q;
  assign round     = round_q;

endmodule

// File: tb/tb_des_round_sequencer.sv
// Directed bench for des_round_sequencer using the classic DES test vectors.
module tb_des_round_sequencer;

  logic        clk = 1'b0;
  logic        rst_n, in_valid, in_ready, decrypt, out_valid, out_ready, busy;
  logic [63:0] data_in, key_in, data_out;
  logic [4:0]  round;

  int checks = 0;
  int errors = 0;
  logic [4:0] round_log [0:39];

  localparam logic [63:0] K1 = 64'h133457799BBCDFF1;
  localparam logic [63:0] P1 = 64'h0123456789ABCDEF;
  localparam logic [63:0] C1 = 64'h85E813540F0AB405;
  localparam logic [63:0] K2 = 64'hA1B2C3D4E5F61234;
  localparam logic [63:0] P2 = 64'h85ABCD1A98876543;
  localparam logic [63:0] C2 = 64'h4BBD010363A955C0;

  des_round_sequencer dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .decrypt(decrypt), .data_in(data_in), .key_in(key_in),
    .out_valid(out_valid), .out_ready(out_ready), .data_out(data_out),
    .busy(busy), .round(round));

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Accept one request, scramble inputs, wait (bounded) for out_valid.
  task automatic do_op(input logic dec, input logic [63:0] key, input logic [63:0] data,
                       output int lat, output logic [63:0] res);
    decrypt = dec; key_in = key; data_in = data; in_valid = 1'b1;
    tick;
    in_valid = 1'b0; decrypt = ~dec; key_in = ~key; data_in = data ^ 64'h5A5A5A5A5A5A5A5A;
    lat = 0;
    while (!out_valid && lat < 40) begin
      round_log[lat] = round;
      tick;
      lat++;
    end
    res = data_out;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; in_valid = 1'b1; decrypt = 1'b0; key_in = K1; data_in = P1; out_ready = 1'b0;
    repeat (3) tick;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b expected 0", busy); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready: got %b expected 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %b expected 0", out_valid); end
    checks++; if (data_out !== 64'd0) begin errors++; $display("FAIL rst_data_out: got %h expected 0", data_out); end
    checks++; if (round !== 5'd0) begin errors++; $display("FAIL rst_round: got %0d expected 0", round); end
    in_valid = 1'b0; rst_n = 1'b1;
    tick;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_release_busy: got %b expected 0", busy); end
  endtask

  task automatic test_encrypt;
    int lat; logic [63:0] res;
    out_ready = 1'b1;
    do_op(1'b0, K1, P1, lat, res);
    checks++; if (lat !== 16) begin errors++; $display("FAIL enc_latency: got %0d expected 16", lat); end
    checks++; if (res !== C1) begin errors++; $display("FAIL enc_data: got %h expected %h", res, C1); end
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (round_log[i] !== 5'(i + 1)) begin errors++; $display("FAIL enc_round_seq: got %0d expected %0d", round_log[i], i + 1); end
    end
    checks++; if (round !== 5'd0) begin errors++; $display("FAIL enc_round_done: got %0d expected 0", round); end
    tick;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL enc_ov_drop: got %b expected 0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL enc_idle: got %b expected 1", in_ready); end
    out_ready = 1'b0;
  endtask

  task automatic test_decrypt;
    int lat; logic [63:0] res;
    out_ready = 1'b0;
    do_op(1'b1, K1, C1, lat, res);
    checks++; if (lat !== 16) begin errors++; $display("FAIL dec_latency: got %0d expected 16", lat); end
    checks++; if (res !== P1) begin errors++; $display("FAIL dec_data: got %h expected %h", res, P1); end
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (round_log[i] !== 5'(i + 1)) begin errors++; $display("FAIL dec_round_seq: got %0d expected %0d", round_log[i], i + 1); end
    end
    out_ready = 1'b1;
    tick;
    out_ready = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL dec_ov_drop: got %b expected 0", out_valid); end
  endtask

  task automatic test_backpressure;
    int lat; logic [63:0] res;
    out_ready = 1'b0;
    do_op(1'b0, K2, P2, lat, res);
    checks++; if (res !== C2) begin errors++; $display("FAIL bp_data: got %h expected %h", res, C2); end
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'($urandom_range(0, 1));
      data_in  = {$urandom, $urandom};
      key_in   = {$urandom, $urandom};
      tick;
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_hold_valid: got %b expected 1", out_valid); end
      checks++; if (data_out !== C2) begin errors++; $display("FAIL bp_hold_data: got %h expected %h", data_out, C2); end
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready: got %b expected 0", in_ready); end
    end
    in_valid = 1'b0; out_ready = 1'b1;
    tick;
    out_ready = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_release: got %b expected 0", out_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL bp_idle: got %b expected 0", busy); end
  endtask

  task automatic test_back_to_back;
    int n; int m; logic got_a; logic [63:0] res_a;
    out_ready = 1'b1; decrypt = 1'b0; key_in = K1; data_in = P1; in_valid = 1'b1;
    tick;
    decrypt = 1'b1; data_in = C1; key_in = K1;
    n = 0; got_a = 1'b0; res_a = 64'd0;
    while (!(got_a && round === 5'd1) && n < 40) begin
      tick;
      n++;
      if (out_valid && !got_a) begin res_a = data_out; got_a = 1'b1; end
    end
    in_valid = 1'b0;
    checks++; if (n !== 18) begin errors++; $display("FAIL b2b_interval: got %0d expected 18", n); end
    checks++; if (res_a !== C1) begin errors++; $display("FAIL b2b_first: got %h expected %h", res_a, C1); end
    m = 0;
    while (!out_valid && m < 40) begin tick; m++; end
    checks++; if (m !== 16) begin errors++; $display("FAIL b2b_latency: got %0d expected 16", m); end
    checks++; if (data_out !== P1) begin errors++; $display("FAIL b2b_second: got %h expected %h", data_out, P1); end
    tick;
    out_ready = 1'b0;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_idle: got %b expected 1", in_ready); end
  endtask

  task automatic test_reset_abort;
    int n; int lat; logic seen; logic [63:0] res;
    out_ready = 1'b1; decrypt = 1'b0; key_in = K1; data_in = P1; in_valid = 1'b1;
    tick;
    in_valid = 1'b0;
    n = 0;
    while (round !== 5'd8 && n < 30) begin tick; n++; end
    checks++; if (round !== 5'd8) begin errors++; $display("FAIL abort_reach8: got %0d expected 8", round); end
    rst_n = 1'b0;
    tick;
    rst_n = 1'b1;
    checks++; if (round !== 5'd0) begin errors++; $display("FAIL abort_round: got %0d expected 0", round); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b expected 0", busy); end
    checks++; if (data_out !== 64'd0) begin errors++; $display("FAIL abort_data: got %h expected 0", data_out); end
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick;
      if (out_valid) seen = 1'b1;
    end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL abort_no_valid: got %b expected 0", seen); end
    do_op(1'b0, K2, P2, lat, res);
    checks++; if (lat !== 16) begin errors++; $display("FAIL abort_next_latency: got %0d expected 16", lat); end
    checks++; if (res !== C2) begin errors++; $display("FAIL abort_next_data: got %h expected %h", res, C2); end
    tick;
    out_ready = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; decrypt = 1'b0; out_ready = 1'b0;
    data_in = 64'd0; key_in = 64'd0;
    test_reset;
    test_encrypt;
    test_decrypt;
    test_backpressure;
    test_back_to_back;
    test_reset_abort;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
